// File: rtl/bpu_next_pc_pkg.sv
// Shared types for the next-fetch-PC unit: branch type codes, counter reset value, BTB entry layout.
package bpu_next_pc_pkg;

    localparam logic [1:0] BR_COND = 2'b00;
    localparam logic [1:0] BR_CALL = 2'b01;
    localparam logic [1:0] BR_RET  = 2'b10;
    localparam logic [1:0] BR_JUMP = 2'b11;

    localparam logic [1:0] CTR_RESET = 2'b01;

    // Tag field is sized for the smallest useful index; unused upper bits stay zero.
    localparam int BTB_TAG_W = 30;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [31:0]          target;
        logic [1:0]           br_type;
    } btb_entry_t;

    function automatic logic [BTB_TAG_W-1:0] btb_tag(input logic [31:0] pc, input int idx_w);
        return BTB_TAG_W'(pc >> (idx_w + 2));
    endfunction

endpackage

// File: rtl/bpu_ras.sv
// Circular return address stack: push/pop/pointer restore, top = entry below the pointer.
// Latency: top is combinational from state; updates land on the clock edge. No backpressure.
// No full/empty tracking: overflow overwrites the oldest entry, underflow reads stale data.
module bpu_ras #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [31:0]      push_dat,
    input  logic             restore_en,
    input  logic [PTR_W-1:0] restore_sp,
    output logic [PTR_W-1:0] sp,
    output logic [31:0]      top
);
    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] sp_q;

    assign sp  = sp_q;
    assign top = mem[sp_q - PTR_W'(1)];

    // Restore only moves the pointer; contents are left as speculation wrote them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sp_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (restore_en) begin
            sp_q <= restore_sp;
        end else if (push) begin
            mem[sp_q] <= push_dat;
            sp_q      <= sp_q + PTR_W'(1);
        end else if (pop) begin
            sp_q <= sp_q - PTR_W'(1);
        end
    end

endmodule

// File: rtl/bpu_next_pc.sv
// Fetch PC register with BTB + gshare + RAS next-PC prediction, backend update and redirect.
// Latency: prediction is combinational from pc; pc/GHR/RAS advance one cycle per accepted fetch.
// Backpressure: fetch_ready=0 freezes pc, GHR and RAS pointer; redirect overrides the stall.
module bpu_next_pc
    import bpu_next_pc_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter int          BTB_IDX_W = 6,
    parameter int          PHT_IDX_W = 8,
    parameter int          GHR_W     = 8,
    parameter int          RAS_DEPTH = 8,
    parameter int          RAS_PTR_W = $clog2(RAS_DEPTH)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 fetch_ready,
    output logic [31:0]          pc,
    output logic                 pc_valid,
    output logic                 pred_taken,
    output logic [1:0]           pred_type,
    output logic [GHR_W-1:0]     ghr_snap,
    output logic [RAS_PTR_W-1:0] ras_sp_snap,
    input  logic                 redirect_en,
    input  logic [31:0]          redirect_pc,
    input  logic [GHR_W-1:0]     redirect_ghr,
    input  logic [RAS_PTR_W-1:0] redirect_ras_sp,
    input  logic                 upd_en,
    input  logic [31:0]          upd_pc,
    input  logic                 upd_taken,
    input  logic [1:0]           upd_type,
    input  logic [31:0]          upd_target,
    input  logic [GHR_W-1:0]     upd_ghr
);
    btb_entry_t         btb [2**BTB_IDX_W];
    logic [1:0]         pht [2**PHT_IDX_W];
    logic [31:0]        pc_q;
    logic               pc_valid_q;
    logic [GHR_W-1:0]   ghr_q;

    logic [BTB_IDX_W-1:0] btb_idx, upd_btb_idx;
    logic [PHT_IDX_W-1:0] pht_idx, upd_pht_idx;
    btb_entry_t           btb_rd;
    logic                 hit, advance, is_push, is_pop;
    logic [31:0]          pc_inc, next_pc, ras_top;
    logic [1:0]           upd_ctr_old, upd_ctr_new;
    logic [RAS_PTR_W-1:0] ras_sp;
    logic                 unused_upd_lsb;

    assign unused_upd_lsb = ^upd_pc[1:0];

    assign btb_idx = pc_q[BTB_IDX_W+1:2];
    assign btb_rd  = btb[btb_idx];
    assign hit     = btb_rd.valid && (btb_rd.tag == btb_tag(pc_q, BTB_IDX_W));
    assign pht_idx = pc_q[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_q);
    assign pc_inc  = pc_q + 32'd4;

    always_comb begin
        next_pc    = pc_inc;
        pred_taken = 1'b0;
        is_push    = 1'b0;
        is_pop     = 1'b0;
        if (hit) begin
            case (btb_rd.br_type)
                BR_COND: begin
                    pred_taken = pht[pht_idx][1];
                    if (pred_taken) next_pc = btb_rd.target;
                end
                BR_CALL: begin
                    pred_taken = 1'b1;
                    next_pc    = btb_rd.target;
                    is_push    = 1'b1;
                end
                BR_RET: begin
                    pred_taken = 1'b1;
                    next_pc    = ras_top;
                    is_pop     = 1'b1;
                end
                default: begin
                    pred_taken = 1'b1;
                    next_pc    = btb_rd.target;
                end
            endcase
        end
    end

    assign advance     = pc_valid_q && fetch_ready && !redirect_en;
    assign pc          = pc_q;
    assign pc_valid    = pc_valid_q;
    assign pred_type   = hit ? btb_rd.br_type : BR_COND;
    assign ghr_snap    = ghr_q;
    assign ras_sp_snap = ras_sp;

    bpu_ras #(.DEPTH(RAS_DEPTH), .PTR_W(RAS_PTR_W)) u_ras (
        .clk        (clk),
        .resetn     (resetn),
        .push       (advance && is_push),
        .pop        (advance && is_pop),
        .push_dat   (pc_inc),
        .restore_en (redirect_en),
        .restore_sp (redirect_ras_sp),
        .sp         (ras_sp),
        .top        (ras_top)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q       <= PC_RESET;
            pc_valid_q <= 1'b0;
            ghr_q      <= '0;
        end else begin
            pc_valid_q <= 1'b1;
            if (redirect_en) begin
                pc_q  <= redirect_pc;
                ghr_q <= redirect_ghr;
            end else if (advance) begin
                pc_q <= next_pc;
                if (hit && btb_rd.br_type == BR_COND) ghr_q <= {ghr_q[GHR_W-2:0], pred_taken};
            end
        end
    end

    assign upd_btb_idx = upd_pc[BTB_IDX_W+1:2];
    assign upd_pht_idx = upd_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(upd_ghr);
    assign upd_ctr_old = pht[upd_pht_idx];

    always_comb begin
        upd_ctr_new = upd_ctr_old;
        if (upd_taken && upd_ctr_old != 2'b11)       upd_ctr_new = upd_ctr_old + 2'd1;
        else if (!upd_taken && upd_ctr_old != 2'b00) upd_ctr_new = upd_ctr_old - 2'd1;
    end

    // Not-taken conditionals are left out of the BTB; a miss already predicts fall-through.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2**BTB_IDX_W; i++) btb[i] <= '0;
        end else if (upd_en && (upd_taken || upd_type != BR_COND)) begin
            btb[upd_btb_idx] <= '{valid: 1'b1, tag: btb_tag(upd_pc, BTB_IDX_W),
                                  target: upd_target, br_type: upd_type};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2**PHT_IDX_W; i++) pht[i] <= CTR_RESET;
        end else if (upd_en && upd_type == BR_COND) begin
            pht[upd_pht_idx] <= upd_ctr_new;
        end
    end

endmodule

// File: doc/bpu_next_pc.md
Name: bpu_next_pc

Overview:
- Parametrised next-fetch-PC unit for the front end: owns the fetch PC register and predicts the next PC each cycle.
- Integrates a tagged direct-mapped BTB, a gshare PHT of 2-bit counters, a global history register (GHR) and a circular return address stack (RAS).
- Adds what the previous single-cycle selector lacked: a backend update port, misprediction redirect with GHR/RAS-pointer recovery, and a fetch stall handshake.

Parameters:
- PC_RESET, 32'h0000_0000, fetch PC after reset.
- BTB_IDX_W, 6, log2 of BTB entries.
- PHT_IDX_W, 8, log2 of PHT counters.
- GHR_W, 8, global history length (GHR_W <= PHT_IDX_W).
- RAS_DEPTH, 8, RAS entries (power of 2); RAS_PTR_W = log2(RAS_DEPTH).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- fetch_ready  in  1  fetch accepts pc this cycle
- pc  out  32  current fetch PC (registered)
- pc_valid  out  1  pc is valid
- pred_taken  out  1  pc predicted to redirect
- pred_type  out  2  BTB type of pc on hit (00 cond, 01 call, 10 return, 11 jump/indirect)
- ghr_snap  out  GHR_W  GHR used for this prediction
- ras_sp_snap  out  RAS_PTR_W  RAS pointer before this prediction
- redirect_en  in  1  backend mispredict/exception redirect
- redirect_pc  in  32  corrected PC
- redirect_ghr  in  GHR_W  GHR to restore
- redirect_ras_sp  in  RAS_PTR_W  RAS pointer to restore
- upd_en  in  1  resolved-branch update
- upd_pc  in  32  PC of the resolved branch
- upd_taken  in  1  actual direction
- upd_type  in  2  actual type
- upd_target  in  32  actual target
- upd_ghr  in  GHR_W  GHR snapshot carried with the branch

Behaviour:
- Reset, asynchronous and active-low:
  - pc = PC_RESET; pc_valid = 0; GHR = 0; RAS pointer = 0; RAS entries = 0.
  - All BTB valid bits = 0; all PHT counters = 2'b01.
- pc_valid goes to 1 on the first clk edge after resetn rises. While pc_valid = 0, the pc register does not advance.
- Lookup (combinational from the pc register):
  - BTB index = pc[BTB_IDX_W+1:2]; tag = pc[31:BTB_IDX_W+2]; hit = valid && tag match.
  - PHT index = pc[PHT_IDX_W+1:2] XOR zero-extended GHR.
- Prediction:
  - No hit: next = pc+4, pred_taken = 0.
  - cond: taken iff counter[1] = 1; target = BTB target, else pc+4.
  - call: taken; next = BTB target; push pc+4.
  - return: taken; next = RAS[sp-1]; pop.
  - jump: taken; next = BTB target.
  - On a miss, pred_type = 00 and is ignored.
- Advance on a clk edge when pc_valid && fetch_ready && !redirect_en:
  - pc <= next.
  - GHR <= {GHR[GHR_W-2:0], pred_taken} only for a cond hit.
  - push: RAS[sp] <= pc+4, sp <= sp+1. pop: sp <= sp-1.
  - RAS is circular. Overflow overwrites the oldest entry. Pop on logically empty returns a stale entry. No empty or full flags.
- Stall: fetch_ready = 0 holds pc, GHR and sp unchanged; outputs stay stable.
- Redirect:
  - redirect_en has priority over advance and stall.
  - pc <= redirect_pc; GHR <= redirect_ghr; sp <= redirect_ras_sp.
  - RAS contents are not restored. Applies in the same edge even if fetch_ready = 0.
  - pc_valid is unaffected.
- Update (independent of redirect and stall, takes effect at the clk edge):
  - If upd_en && (upd_taken || upd_type != 00): write BTB entry at upd_pc's index with valid = 1, tag, upd_target, upd_type. This overwrites any prior entry there.
  - If upd_en && upd_type == 00: PHT[upd_pc[PHT_IDX_W+1:2] ^ upd_ghr] saturating +1 if taken, -1 if not, clamped at 00/11.
  - A lookup in the same cycle as an update to the same entry sees the old value.
- All PC arithmetic is 32-bit modulo; pc+4 wraps at 32'hFFFF_FFFC.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

Decomposition:
- Shared package holds:
  - BR_COND/BR_CALL/BR_RET/BR_JUMP 2-bit type constants.
  - CTR_RESET = 2'b01.
  - BTB entry struct fields (valid, tag, target, type).
- One sub-module: bpu_ras (circular stack with push, pop, pointer restore, top output).
- BTB, PHT and GHR stay inline.

Test Plan:
- Reset, then fetch_ready = 1 for 4 cycles with no updates -> pc = 0x0, 0x4, 0x8, 0xC; pred_taken = 0; pc_valid rises 1 cycle after resetn.
- Update pc 0x10 cond, taken, target 0x80, upd_ghr = 0 twice -> counter reaches 11. With GHR = 0, fetch at 0x10 gives next pc 0x80 and GHR LSB = 1.
- Call at 0x20 (BTB type 01, target 0x100), then return at 0x104 (type 10) -> pc 0x20, 0x100, 0x104, 0x24; sp goes 0, 1, 0.
- Push RAS_DEPTH+1 calls with no returns -> sp wraps to 1; the oldest entry is overwritten by the newest return address.
- Same cycle: redirect_en with pc 0x200, ghr 0x5A, sp 3, plus fetch_ready = 0 -> next pc = 0x200, ghr_snap = 0x5A, ras_sp_snap = 3.
- Assert resetn = 0 asynchronously mid-run while pc = 0x80 -> pc = 0x0 and pc_valid = 0 before the next clk edge; BTB misses afterwards.
